// File: rtl/cla_addsub_pipe_if.sv
// Valid/ready operand and result bundle for cla_addsub_pipe.
// master drives operands and out_ready; slave is the adder pipe.
interface cla_addsub_pipe_if #(
   parameter int WIDTH = 16
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic             Cin;
   logic             control;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             Cout;
   logic             overflow;
   logic             zero;

   modport master (
      output in_valid, A, B, Cin, control, out_ready,
      input  in_ready, out_valid, sum, Cout, overflow, zero
   );

   modport slave (
      input  in_valid, A, B, Cin, control, out_ready,
      output in_ready, out_valid, sum, Cout, overflow, zero
   );
endinterface

// File: rtl/cla_addsub_pipe.sv
// Pipelined CLA add/sub: one GROUP-bit look-ahead block per stage.
// Define CLA_SAT_EN to clamp signed overflow to the signed limits.
module cla_addsub_pipe #(
   parameter int WIDTH = 16,
   parameter int GROUP = 4
) (
   input logic              clk,
   input logic              rst_n,
   cla_addsub_pipe_if.slave bus
);
   localparam int LAT = WIDTH / GROUP;

   logic             adv;
   logic             out_v;
   logic             cout_q;
   logic             ovf_q;
   logic             zero_q;
   logic [WIDTH-1:0] sum_q;

   // Flattened look-ahead: every carry is a sum of g/p products.
   function automatic logic [GROUP:0] cla(
      input logic [GROUP-1:0] g,
      input logic [GROUP-1:0] p,
      input logic             ci
   );
      logic [GROUP:0] c;
      logic           t;
      c    = '0;
      c[0] = ci;
      for (int i = 0; i < GROUP; i++) begin
         t = ci;
         for (int k = 0; k <= i; k++) t = t & p[k];
         c[i+1] = t;
         for (int j = 0; j <= i; j++) begin
            t = g[j];
            for (int k = j + 1; k <= i; k++) t = t & p[k];
            c[i+1] = c[i+1] | t;
         end
      end
      return c;
   endfunction

   assign adv          = ~out_v | bus.out_ready;
   assign bus.in_ready = adv;
   assign bus.out_valid = out_v;
   assign bus.sum      = sum_q;
   assign bus.Cout     = cout_q;
   assign bus.overflow = ovf_q;
   assign bus.zero     = zero_q;

   for (genvar k = 0; k < LAT; k++) begin : g_stage
      localparam int LO = k * GROUP;
      localparam int RW = WIDTH - LO;

      logic [RW-1:0]       xa;
      logic [RW-1:0]       xb;
      logic                xc;
      logic                xv;
      logic [GROUP-1:0]    gg;
      logic [GROUP-1:0]    gp;
      logic [GROUP-1:0]    gs;
      logic [GROUP:0]      c;
      logic [LO+GROUP-1:0] ns;

      // Subtraction inverts B once at entry; control is not carried.
      if (k == 0) begin : g_src
         assign xa = bus.A;
         assign xb = bus.B ^ {WIDTH{bus.control}};
         assign xc = bus.Cin;
         assign xv = bus.in_valid;
         assign ns = gs;
      end else begin : g_src
         assign xa = g_stage[k-1].g_reg.ra;
         assign xb = g_stage[k-1].g_reg.rb;
         assign xc = g_stage[k-1].g_reg.rc;
         assign xv = g_stage[k-1].g_reg.rv;
         assign ns = {gs, g_stage[k-1].g_reg.rs};
      end

      assign gg = xa[GROUP-1:0] & xb[GROUP-1:0];
      assign gp = xa[GROUP-1:0] ^ xb[GROUP-1:0];
      assign c  = cla(gg, gp, xc);
      assign gs = gp ^ c[GROUP-1:0];

      if (k < LAT - 1) begin : g_reg
         logic                rv;
         logic                rc;
         logic [RW-GROUP-1:0] ra;
         logic [RW-GROUP-1:0] rb;
         logic [LO+GROUP-1:0] rs;

         always_ff @(posedge clk) begin
            if (!rst_n) begin
               rv <= 1'b0;
               rc <= 1'b0;
               ra <= '0;
               rb <= '0;
               rs <= '0;
            end else if (adv) begin
               rv <= xv;
               rc <= c[GROUP];
               ra <= xa[RW-1:GROUP];
               rb <= xb[RW-1:GROUP];
               rs <= ns;
            end
         end
      end else begin : g_out
         logic             ovf;
         logic [WIDTH-1:0] fin;

         assign ovf = c[GROUP] ^ c[GROUP-1];

         // On overflow both operand MSBs agree and give the true sign.
         always_comb begin
            fin = ns;
`ifdef CLA_SAT_EN
            if (ovf) begin
               fin = xa[GROUP-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                 : {1'b0, {(WIDTH-1){1'b1}}};
            end
`endif
         end

         always_ff @(posedge clk) begin
            if (!rst_n) begin
               out_v  <= 1'b0;
               sum_q  <= '0;
               cout_q <= 1'b0;
               ovf_q  <= 1'b0;
               zero_q <= 1'b0;
            end else if (adv) begin
               out_v  <= xv;
               sum_q  <= fin;
               cout_q <= c[GROUP];
               ovf_q  <= ovf;
               zero_q <= (fin == '0);
            end
         end
      end
   end
endmodule
